// File: rtl/uart_echo_ctrl_if.sv
// uart_echo_ctrl_if: FIFO-side handshake between the echo controller and the uart core.
// Latency: none, plain wires; the controller drives pops/pushes, the core drives status.
// Backpressure: rx_empty and tx_full from the core gate rd_uart and wr_uart.
interface uart_echo_ctrl_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx_empty;
  logic [DATA_BITS-1:0] r_data;
  logic                 rd_uart;
  logic                 tx_full;
  logic                 wr_uart;
  logic [DATA_BITS-1:0] w_data;

  // Controller side: issues pops and pushes, observes FIFO status.
  modport master (
    input  rx_empty,
    input  r_data,
    input  tx_full,
    output rd_uart,
    output wr_uart,
    output w_data
  );

  // uart core side: supplies FIFO status, receives pops and pushes.
  modport slave (
    output rx_empty,
    output r_data,
    output tx_full,
    input  rd_uart,
    input  wr_uart,
    input  w_data
  );
endinterface

// File: rtl/uart_echo_ctrl.sv
// uart_echo_ctrl: run-time selectable idle / pin loopback / FIFO echo / XOR echo, plus debug monitors.
// Latency: rx pin to tx pin SYNC_STAGES+1 clk in loopback; FIFO pop to push 1 clk, one byte per 2 clk.
// Backpressure: tx_full parks the echoed byte in HOLD (busy=1) and blocks further rx pops.
module uart_echo_ctrl #(
  parameter int                   DATA_BITS   = 8,
  parameter int                   SYNC_STAGES = 2,
  parameter logic [DATA_BITS-1:0] XOR_MASK    = DATA_BITS'(8'h20),
  parameter int                   CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  input  logic [1:0]        mode,
  input  logic              uart_tx,
  uart_echo_ctrl_if.master  fifo,
  output logic              tx,
  output logic              rx_monitor,
  output logic              tx_monitor,
  output logic              busy,
  output logic [CNT_W-1:0]  rx_count,
  output logic [CNT_W-1:0]  tx_count
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t               state_q;
  state_t               state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 rx_s;
  logic                 pop;
  logic                 push;
  logic [DATA_BITS-1:0] pop_data;
  logic [DATA_BITS-1:0] hold_q;
  logic [DATA_BITS-1:0] last_q;

  // The rx pin is asynchronous; only the last synchroniser stage is used internally.
  assign rx_s = sync_q[SYNC_STAGES-1];

  // Transform is decided at pop time; pops only happen in modes 2/3, so mode[0] selects XOR.
  assign pop_data = mode[0] ? (fifo.r_data ^ XOR_MASK) : fifo.r_data;

  assign fifo.rd_uart = pop;
  assign fifo.wr_uart = push;
  // w_data shows the held byte only during the push cycle and otherwise keeps the last byte sent.
  assign fifo.w_data  = push ? hold_q : last_q;

  // Synchroniser chain for rx; resets to mark (1) so the line looks idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end
  end

  // Registered tx pin mux and the two debug pin monitors.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx         <= 1'b1;
      rx_monitor <= 1'b1;
      tx_monitor <= 1'b1;
    end else begin
      rx_monitor <= rx_s;
      tx_monitor <= tx;
      unique case (mode)
        2'd0:    tx <= 1'b1;
        2'd1:    tx <= rx_s;
        default: tx <= uart_tx;
      endcase
    end
  end

  // Echo FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Echo FSM next state: a pop moves to HOLD, a push returns to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (pop)  state_d = S_HOLD;
      S_HOLD: if (push) state_d = S_IDLE;
    endcase
  end

  // Echo FSM outputs; pop and push live in different states so they never coincide.
  always_comb begin
    pop  = 1'b0;
    push = 1'b0;
    busy = 1'b0;
    unique case (state_q)
      S_IDLE: pop = !reset && mode[1] && !fifo.rx_empty;
      S_HOLD: begin
        busy = 1'b1;
        // A pending byte is flushed whatever the current mode, so no byte is lost.
        push = !reset && !fifo.tx_full;
      end
    endcase
  end

  // Holding register captures the (possibly transformed) byte; last_q tracks what was sent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q <= '0;
      last_q <= '0;
    end else begin
      if (pop)  hold_q <= pop_data;
      if (push) last_q <= hold_q;
    end
  end

  // Saturating pop/push counters for debug; they stick at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_count <= '0;
      tx_count <= '0;
    end else begin
      if (pop && rx_count != CNT_MAX)  rx_count <= rx_count + CNT_W'(1);
      if (push && tx_count != CNT_MAX) tx_count <= tx_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_uart_echo_ctrl.sv
// tb_uart_echo_ctrl: directed stimulus with a queue-level echo/pin model checked every cycle.
// Latency: inputs change just after posedge, outputs compared at negedge.
// Backpressure: bench drives tx_full directly and fakes the rx FIFO with a queue.
module tb_uart_echo_ctrl;
  localparam int DB   = 8;
  localparam int SYNC = 2;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;
  localparam logic [DB-1:0] MASK = 8'h20;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx = 1'b1;
  logic [1:0]    mode = 2'd0;
  logic          uart_tx = 1'b1;
  logic          tx;
  logic          rx_monitor;
  logic          tx_monitor;
  logic          busy;
  logic [CW-1:0] rx_count;
  logic [CW-1:0] tx_count;

  uart_echo_ctrl_if #(.DATA_BITS(DB)) ifc ();

  uart_echo_ctrl #(
    .DATA_BITS(DB), .SYNC_STAGES(SYNC), .XOR_MASK(MASK), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .rx(rx), .mode(mode), .uart_tx(uart_tx),
    .fifo(ifc), .tx(tx), .rx_monitor(rx_monitor), .tx_monitor(tx_monitor),
    .busy(busy), .rx_count(rx_count), .tx_count(tx_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- fake uart rx FIFO and observation ----------------
  logic [DB-1:0] rxq[$];
  logic [DB-1:0] wr_log[$];
  bit            rd_seen = 0;
  int            rd_pulses = 0;

  task automatic refresh();
    ifc.rx_empty = (rxq.size() == 0);
    ifc.r_data   = (rxq.size() != 0) ? rxq[0] : '0;
  endtask

  task automatic push_byte(input logic [DB-1:0] b);
    rxq.push_back(b);
    refresh();
  endtask

  function automatic int get_log(input int i);
    if (i < wr_log.size()) return int'(wr_log[i]);
    return -1;
  endfunction

  always @(posedge clk) begin
    #1;
    if (rd_seen && rxq.size() != 0) void'(rxq.pop_front());
    rd_seen = 0;
    refresh();
  end

  always @(negedge clk) begin
    rd_seen = ifc.rd_uart;
    if (ifc.rd_uart) rd_pulses++;
    if (ifc.wr_uart) wr_log.push_back(ifc.w_data);
  end

  // ---------------- behavioural model ----------------
  bit            m_held = 0;
  logic [DB-1:0] m_byte = '0;
  logic [DB-1:0] m_last = '0;
  int            m_rxc = 0;
  int            m_txc = 0;
  bit            rxh[$];
  bit            m_tx = 1, m_txm = 1, m_rxm = 1;
  bit            m_s;
  bit            exp_rd = 0, exp_wr = 0;
  logic [DB-1:0] exp_wd;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_held = 0; m_byte = '0; m_last = '0; m_rxc = 0; m_txc = 0;
      rxh.delete(); m_tx = 1; m_txm = 1; m_rxm = 1;
    end else begin
      // rx seen by the core at this edge is the pin value SYNC edges earlier (mark before reset).
      rxh.push_back(rx);
      m_s   = (rxh.size() > SYNC) ? rxh[rxh.size()-1-SYNC] : 1'b1;
      m_txm = m_tx;
      m_rxm = m_s;
      m_tx  = (mode == 2'd0) ? 1'b1 : (mode == 2'd1) ? m_s : uart_tx;
      if (exp_rd) begin
        m_held = 1;
        m_byte = (mode == 2'd3) ? (ifc.r_data ^ MASK) : ifc.r_data;
        if (m_rxc < CMAX) m_rxc++;
      end
      if (exp_wr) begin
        m_held = 0;
        m_last = m_byte;
        if (m_txc < CMAX) m_txc++;
      end
      if (rxh.size() > 16) void'(rxh.pop_front());
    end
  end

  always @(negedge clk) begin
    exp_rd = !reset && !m_held && mode[1] && !ifc.rx_empty;
    exp_wr = !reset && m_held && !ifc.tx_full;
    exp_wd = exp_wr ? m_byte : m_last;
    chk("rd_uart", ifc.rd_uart, exp_rd);
    chk("wr_uart", ifc.wr_uart, exp_wr);
    chk("w_data", ifc.w_data, exp_wd);
    chk("busy", busy, m_held);
    chk("tx", tx, m_tx);
    chk("tx_monitor", tx_monitor, m_txm);
    chk("rx_monitor", rx_monitor, m_rxm);
    chk("rx_count", rx_count, m_rxc);
    chk("tx_count", tx_count, m_txc);
    chk("rd_wr_excl", ifc.rd_uart & ifc.wr_uart, 0);
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  // ---------------- directed stimulus with literal expectations ----------------
  initial begin
    ifc.tx_full = 1'b0;
    refresh();
    step(2);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_w_data", ifc.w_data, 0);
    chk("rst_rx_count", rx_count, 0);
    reset = 1'b0;

    // Pin loopback: falling rx edge reaches tx on the third edge.
    mode = 2'd1;
    step(3);
    rx = 1'b0;
    step(); chk("m1_tx_e1", tx, 1);
    step(); chk("m1_tx_e2", tx, 1);
    step(); chk("m1_tx_e3", tx, 0); chk("m1_txmon_e3", tx_monitor, 1);
    step(); chk("m1_txmon_e4", tx_monitor, 0);
    mode = 2'd0;
    step(); chk("m0_tx_idle", tx, 1);
    rx = 1'b1;
    step(3);

    // Plain echo.
    mode = 2'd2;
    uart_tx = 1'b0;
    push_byte(8'h41);
    step(4);
    chk("echo_byte", get_log(0), 32'h41);
    chk("echo_rxc", rx_count, 1);
    chk("echo_txc", tx_count, 1);
    chk("echo_pops", rd_pulses, 1);
    chk("w_data_hold", ifc.w_data, 8'h41);

    // XOR echo.
    mode = 2'd3;
    push_byte(8'h61);
    push_byte(8'h5A);
    step(6);
    chk("xor_61", get_log(1), 32'h41);
    chk("xor_5a", get_log(2), 32'h7A);

    // Counters saturate at 3 after five bytes.
    mode = 2'd2;
    push_byte(8'h01);
    push_byte(8'h02);
    step(6);
    chk("sat_log_n", wr_log.size(), 5);
    chk("sat_rxc", rx_count, 3);
    chk("sat_txc", tx_count, 3);

    // Backpressure: byte held, no further pops while tx_full.
    ifc.tx_full = 1'b1;
    push_byte(8'h10);
    push_byte(8'h11);
    step(10);
    chk("bp_busy", busy, 1);
    chk("bp_pops", rd_pulses, 6);
    chk("bp_log_n", wr_log.size(), 5);
    chk("bp_rxq", rxq.size(), 1);
    ifc.tx_full = 1'b0;
    step(5);
    chk("bp_first", get_log(5), 32'h10);
    chk("bp_second", get_log(6), 32'h11);
    chk("bp_pops_after", rd_pulses, 7);

    // Mode drop during HOLD: held XOR byte still written, no new pop.
    ifc.tx_full = 1'b1;
    mode = 2'd3;
    push_byte(8'h30);
    step(3);
    mode = 2'd0;
    push_byte(8'h31);
    step(3);
    chk("mc_busy", busy, 1);
    ifc.tx_full = 1'b0;
    step(4);
    chk("mc_byte", get_log(7), 32'h10);
    chk("mc_rxq", rxq.size(), 1);
    chk("mc_pops", rd_pulses, 8);

    // Async reset mid-cycle while a byte is held: byte dropped.
    mode = 2'd2;
    ifc.tx_full = 1'b1;
    step(3);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_tx", tx, 0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_tx", tx, 1);
    chk("arst_busy", busy, 0);
    chk("arst_rd", ifc.rd_uart, 0);
    chk("arst_wr", ifc.wr_uart, 0);
    chk("arst_w_data", ifc.w_data, 0);
    chk("arst_rxc", rx_count, 0);
    chk("arst_txc", tx_count, 0);
    chk("arst_txmon", tx_monitor, 1);
    chk("arst_rxmon", rx_monitor, 1);
    step();
    reset = 1'b0;
    ifc.tx_full = 1'b0;
    mode = 2'd0;
    step(5);
    chk("arst_dropped", wr_log.size(), 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uart_echo_ctrl.md
Name: uart_echo_ctrl

Overview:
Parametrised loopback/echo controller that sits between the board UART pins and the FIFO interface of the existing uart core (rx_empty/r_data/rd_uart, tx_full/w_data/wr_uart). It selects among four modes at run time: line idle, raw pin loopback, byte echo through the UART FIFOs, and byte echo with an XOR transform. It also provides synchronised pin monitors and saturating byte counters for debug.

Parameters:
DATA_BITS, 8, width of r_data/w_data and of the echo holding register
SYNC_STAGES, 2, flip-flop stages on the rx pin before any internal use (minimum 2)
XOR_MASK, 8'h20, value XORed into echoed bytes in mode 3; width DATA_BITS
CNT_W, 16, width of rx_count/tx_count

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
rx  input  1  UART receive pin (asynchronous to clk)
mode  input  2  0=idle, 1=pin loopback, 2=echo, 3=echo+XOR
uart_tx  input  1  serial output of uart core
rx_empty  input  1  uart rx FIFO empty
r_data  input  DATA_BITS  uart rx FIFO head, valid while rx_empty=0
tx_full  input  1  uart tx FIFO full
rd_uart  output  1  pop rx FIFO, single-cycle pulse
wr_uart  output  1  push tx FIFO, single-cycle pulse
w_data  output  DATA_BITS  byte for tx FIFO, valid with wr_uart
tx  output  1  UART transmit pin
rx_monitor  output  1  synchronised rx
tx_monitor  output  1  registered copy of tx
busy  output  1  echo byte held, waiting for tx FIFO space
rx_count  output  CNT_W  bytes popped from rx FIFO, saturating
tx_count  output  CNT_W  bytes pushed to tx FIFO, saturating

Behaviour:
- Reset (async, active-high): sync chain=all 1; tx=1; rx_monitor=1; tx_monitor=1; rd_uart=0; wr_uart=0; w_data=0; busy=0; counters=0; FSM=IDLE. Reset mid-transaction drops the held byte without writing it.
- rx_s = last stage of the SYNC_STAGES chain; rx_monitor <= rx_s.
- tx is registered: mode 0 -> 1 (mark/idle); mode 1 -> rx_s; modes 2/3 -> uart_tx. tx_monitor <= tx (one more cycle). An rx edge reaches tx in mode 1 after SYNC_STAGES+1 clk edges.
- Echo FSM, two states:
  - IDLE: if mode[1]=1 and rx_empty=0, then buf <= r_data (mode 3: r_data ^ XOR_MASK; latched mode), rd_uart=1 for that cycle, rx_count++, go to HOLD. Otherwise rd_uart=0.
  - HOLD: busy=1. If tx_full=0: wr_uart=1, w_data=buf, tx_count++, go to IDLE. If tx_full=1: stay, wr_uart=0.
- Transform is chosen at pop time; a mode change during HOLD does not alter buf.
- A mode change to 0/1 during HOLD still completes the pending write (no byte loss). New pops occur only in modes 2/3.
- Maximum throughput: one byte per 2 cycles (pop and push are never in the same cycle).
- rd_uart is never asserted while rx_empty=1; wr_uart is never asserted while tx_full=1; rd_uart and wr_uart are never both 1.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- w_data holds its last value between writes.

Test Plan:
- Reset: assert reset asynchronously mid-clock -> all outputs take reset values immediately, tx=1, counters=0.
- Mode 1: mode=1, toggle rx 1->0 -> tx=0 exactly 3 clk edges later (SYNC_STAGES=2), tx_monitor=0 one edge after that; mode=0 -> tx=1 next edge.
- Mode 2 echo: rx FIFO presents 8'h41, tx_full=0 -> rd_uart pulse one cycle, next cycle wr_uart with w_data=8'h41; rx_count=tx_count=1.
- Mode 3 transform: r_data=8'h61 -> w_data=8'h41; r_data=8'h5A -> 8'h7A.
- Backpressure: tx_full=1 for 10 cycles with byte held -> busy=1, wr_uart=0, no further rd_uart despite rx_empty=0; release -> one wr_uart, then the next pop.
- Mode change/saturation: switch to mode 0 during HOLD -> pending byte still written, no new pops; with CNT_W=2, echo 5 bytes -> rx_count=tx_count=3.
